// File: rtl/ss_pkg.sv
// Shared definitions for the find-min scanner: FSM state encoding and
// default widths for the RAM address and data buses.
package ss_pkg;

  localparam int DEFAULT_SIZE_ADDR = 6;
  localparam int DEFAULT_SIZE_DATA = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } ss_state_t;

endpackage : ss_pkg

// File: rtl/ss_find_min.sv
// Streaming minimum search over a range of RAM words. The upstream read
// stage streams words with i_data_valid; the block tracks the smallest
// value and the address it came from, then pulses o_done_find_min one
// cycle after the upstream end-of-range pulse.
//
// Build option: define SS_FIND_MIN_DESCEND_EN to search for the maximum
// instead of the minimum. Ties keep the earliest address in both modes.
module ss_find_min #(
  parameter int SIZE_ADDR = ss_pkg::DEFAULT_SIZE_ADDR,
  parameter int SIZE_DATA = ss_pkg::DEFAULT_SIZE_DATA
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start_find_min,
  input  logic [SIZE_ADDR-1:0] i_si_ram,
  input  logic                 i_data_valid,
  input  logic [SIZE_DATA-1:0] i_data_ram,
  input  logic                 i_done_read_data,
  output logic [SIZE_DATA-1:0] o_min_data,
  output logic [SIZE_ADDR-1:0] o_min_addr,
  output logic                 o_found,
  output logic                 o_busy,
  output logic                 o_done_find_min
);

  import ss_pkg::*;

  ss_state_t            state;
  logic [SIZE_ADDR-1:0] addr_cnt;

  // Strict comparison so an equal value never displaces an earlier address.
  function automatic logic is_better(input logic [SIZE_DATA-1:0] cand,
                                     input logic [SIZE_DATA-1:0] best);
`ifdef SS_FIND_MIN_DESCEND_EN
    return cand > best;
`else
    return cand < best;
`endif
  endfunction

  // Scan controller: a start pulse always (re)loads the scan regardless of
  // state, so an aborted scan never reaches DONE and never pulses done.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state           <= IDLE;
      addr_cnt        <= '0;
      o_min_data      <= '0;
      o_min_addr      <= '0;
      o_found         <= 1'b0;
      o_busy          <= 1'b0;
      o_done_find_min <= 1'b0;
    end else begin
      o_done_find_min <= 1'b0;
      if (i_start_find_min) begin
        state      <= SCAN;
        o_busy     <= 1'b1;
        addr_cnt   <= i_si_ram;
        o_found    <= 1'b0;
        o_min_data <= '0;
        o_min_addr <= i_si_ram;
      end else begin
        case (state)
          IDLE: begin
            state <= IDLE;
          end
          SCAN: begin
            if (i_data_valid) begin
              if (!o_found || is_better(i_data_ram, o_min_data)) begin
                o_min_data <= i_data_ram;
                o_min_addr <= addr_cnt;
              end
              o_found  <= 1'b1;
              addr_cnt <= addr_cnt + 1'b1;
            end
            if (i_done_read_data) begin
              state           <= DONE;
              o_busy          <= 1'b0;
              o_done_find_min <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule : ss_find_min

// File: tb/tb_ss_find_min.sv
// Directed, table-driven bench for ss_find_min. Expected results are
// hand-computed for both the minimum and (SS_FIND_MIN_DESCEND_EN) maximum
// builds.
module tb_ss_find_min;

  logic       i_clk;
  logic       i_rst;
  logic       i_start_find_min;
  logic [5:0] i_si_ram;
  logic       i_data_valid;
  logic [7:0] i_data_ram;
  logic       i_done_read_data;
  logic [7:0] o_min_data;
  logic [5:0] o_min_addr;
  logic       o_found;
  logic       o_busy;
  logic       o_done_find_min;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [5:0]      si;
    logic [3:0]      n;
    logic [7:0][7:0] d;
    logic [7:0]      exp_data;
    logic [5:0]      exp_addr;
    logic            exp_found;
  } vec_t;

  vec_t vecs [6];

  ss_find_min dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_start_find_min (i_start_find_min),
    .i_si_ram         (i_si_ram),
    .i_data_valid     (i_data_valid),
    .i_data_ram       (i_data_ram),
    .i_done_read_data (i_done_read_data),
    .o_min_data       (o_min_data),
    .o_min_addr       (o_min_addr),
    .o_found          (o_found),
    .o_busy           (o_busy),
    .o_done_find_min  (o_done_find_min)
  );

  // 10 ns clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Hard time limit so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(input logic [5:0] si, input int n,
                              input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d,
                              input logic [7:0] e, input logic [7:0] f,
                              input logic [7:0] ed, input logic [5:0] ea,
                              input logic ef);
    vec_t r;
    r.si        = si;
    r.n         = n[3:0];
    r.d[0]      = a;
    r.d[1]      = b;
    r.d[2]      = c;
    r.d[3]      = d;
    r.d[4]      = e;
    r.d[5]      = f;
    r.d[6]      = 8'd0;
    r.d[7]      = 8'd0;
    r.exp_data  = ed;
    r.exp_addr  = ea;
    r.exp_found = ef;
    return r;
  endfunction

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, actual, expected);
    end
  endtask

  // Stream the vector's beats (done on the last beat, or alone when empty)
  // and check the one-cycle done pulse and the held results.
  task automatic streamBeats(input vec_t v, input string tag);
    if (v.n == 0) begin
      i_done_read_data = 1'b1;
      tick();
    end else begin
      for (int i = 0; i < int'(v.n); i++) begin
        i_data_valid     = 1'b1;
        i_data_ram       = v.d[i];
        i_done_read_data = (i == int'(v.n) - 1);
        tick();
      end
    end
    i_data_valid     = 1'b0;
    i_done_read_data = 1'b0;
    checkOutput({tag, ".done"},  o_done_find_min, 1);
    checkOutput({tag, ".data"},  o_min_data,      v.exp_data);
    checkOutput({tag, ".addr"},  o_min_addr,      v.exp_addr);
    checkOutput({tag, ".found"}, o_found,         v.exp_found);
    checkOutput({tag, ".busy"},  o_busy,          0);
    tick();
    checkOutput({tag, ".done_1cyc"}, o_done_find_min, 0);
    checkOutput({tag, ".hold"},      o_min_data,      v.exp_data);
  endtask

  task automatic applyStimulus(input vec_t v, input string tag);
    i_si_ram         = v.si;
    i_start_find_min = 1'b1;
    tick();
    i_start_find_min = 1'b0;
    checkOutput({tag, ".busy_scan"}, o_busy, 1);
    streamBeats(v, tag);
  endtask

  initial begin
    vec_t g;
    i_rst            = 1'b1;
    i_start_find_min = 1'b0;
    i_si_ram         = '0;
    i_data_valid     = 1'b0;
    i_data_ram       = '0;
    i_done_read_data = 1'b0;

`ifdef SS_FIND_MIN_DESCEND_EN
    vecs[0] = mk(6'd5,  6, 40, 12, 33, 12, 90, 7, 8'd90,  6'd9,  1'b1);
    vecs[1] = mk(6'd0,  4,  9,  3,  3,  8,  0, 0, 8'd9,   6'd0,  1'b1);
    vecs[2] = mk(6'd62, 4,  5,  6,  1,  4,  0, 0, 8'd6,   6'd63, 1'b1);
    vecs[5] = mk(6'd10, 3,  0, 255, 0,  0,  0, 0, 8'd255, 6'd11, 1'b1);
`else
    vecs[0] = mk(6'd5,  6, 40, 12, 33, 12, 90, 7, 8'd7,   6'd10, 1'b1);
    vecs[1] = mk(6'd0,  4,  9,  3,  3,  8,  0, 0, 8'd3,   6'd1,  1'b1);
    vecs[2] = mk(6'd62, 4,  5,  6,  1,  4,  0, 0, 8'd1,   6'd0,  1'b1);
    vecs[5] = mk(6'd10, 3,  0, 255, 0,  0,  0, 0, 8'd0,   6'd10, 1'b1);
`endif
    vecs[3] = mk(6'd20, 0,  0,  0,  0,  0,  0, 0, 8'd0,   6'd20, 1'b0);
    vecs[4] = mk(6'd3,  1, 200, 0,  0,  0,  0, 0, 8'd200, 6'd3,  1'b1);

    // Reset state
    repeat (2) @(posedge i_clk);
    #1;
    checkOutput("rst.data",  o_min_data,      0);
    checkOutput("rst.addr",  o_min_addr,      0);
    checkOutput("rst.found", o_found,         0);
    checkOutput("rst.busy",  o_busy,          0);
    checkOutput("rst.done",  o_done_find_min, 0);
    i_rst = 1'b0;

    // Table-driven scans
    for (int k = 0; k < 6; k++)
      applyStimulus(vecs[k], $sformatf("vec%0d", k));

    // Valid gaps: beats 8,9, three idle cycles, then 10,11,12
    i_si_ram         = 6'd32;
    i_start_find_min = 1'b1;
    tick();
    i_start_find_min = 1'b0;
    i_data_valid = 1'b1; i_data_ram = 8'd8; tick();
    i_data_ram = 8'd9; tick();
    i_data_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("gap.busy%0d", i), o_busy, 1);
      tick();
    end
    i_data_valid = 1'b1; i_data_ram = 8'd10; tick();
    i_data_ram = 8'd11; tick();
`ifdef SS_FIND_MIN_DESCEND_EN
    g = mk(6'd32, 1, 12, 0, 0, 0, 0, 0, 8'd12, 6'd36, 1'b1);
`else
    g = mk(6'd32, 1, 12, 0, 0, 0, 0, 0, 8'd8,  6'd32, 1'b1);
`endif
    streamBeats(g, "gap");

    // Valid beats while idle must not disturb the held result
    i_data_valid = 1'b1;
    i_data_ram   = 8'd0;
    tick();
    tick();
    i_data_valid = 1'b0;
    checkOutput("idle_valid.data",  o_min_data, g.exp_data);
    checkOutput("idle_valid.addr",  o_min_addr, g.exp_addr);
    checkOutput("idle_valid.found", o_found,    1);

    // Reset mid-scan clears outputs immediately, start accepted right after
    i_si_ram         = 6'd40;
    i_start_find_min = 1'b1;
    tick();
    i_start_find_min = 1'b0;
    i_data_valid = 1'b1; i_data_ram = 8'd1; tick();
    i_data_ram = 8'd2; tick();
    i_data_valid = 1'b0;
    checkOutput("pre_rst.found", o_found, 1);
    i_rst = 1'b1;
    #1;
    checkOutput("async_rst.data",  o_min_data,      0);
    checkOutput("async_rst.addr",  o_min_addr,      0);
    checkOutput("async_rst.found", o_found,         0);
    checkOutput("async_rst.busy",  o_busy,          0);
    checkOutput("async_rst.done",  o_done_find_min, 0);
    i_rst = 1'b0;
    i_si_ram         = 6'd0;
    i_start_find_min = 1'b1;
    tick();
    i_start_find_min = 1'b0;
    checkOutput("post_rst.busy", o_busy, 1);
    streamBeats(vecs[1], "post_rst");

    // Restart mid-scan: start wins over a same-cycle beat, no done pulse
    i_si_ram         = 6'd50;
    i_start_find_min = 1'b1;
    tick();
    i_start_find_min = 1'b0;
    i_data_valid = 1'b1; i_data_ram = 8'd1; tick();
    i_data_ram = 8'd1; tick();
    i_si_ram         = 6'd0;
    i_start_find_min = 1'b1;
    i_data_ram       = 8'd0;
    tick();
    i_start_find_min = 1'b0;
    i_data_valid     = 1'b0;
    checkOutput("restart.done",  o_done_find_min, 0);
    checkOutput("restart.busy",  o_busy,          1);
    checkOutput("restart.found", o_found,         0);
    checkOutput("restart.addr",  o_min_addr,      0);
    streamBeats(vecs[1], "restart");

    // Start and done together in IDLE: start wins, done is ignored
    i_si_ram         = 6'd7;
    i_start_find_min = 1'b1;
    i_done_read_data = 1'b1;
    tick();
    i_start_find_min = 1'b0;
    i_done_read_data = 1'b0;
    checkOutput("start_done.busy", o_busy,          1);
    checkOutput("start_done.done", o_done_find_min, 0);
    tick();
    checkOutput("start_done.still_scan", o_busy, 1);
    streamBeats(mk(6'd7, 0, 0, 0, 0, 0, 0, 0, 8'd0, 6'd7, 1'b0), "start_done");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_ss_find_min
